// File: rtl/viterbi_acs_sequencer.sv
// Front-end sequencer for the 64-state K=7 Viterbi ACS array: branch metrics,
// ACS clear/step strobes, decision write-back and traceback launch.
module viterbi_acs_sequencer #(
  parameter int MAX_SYMS = 48,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_bits,
  input  logic              in_last,
  output logic [7:0]        metrics,
  output logic              acs_clear,
  output logic              acs_step,
  input  logic [63:0]       dec_in,
  output logic              dec_wr_en,
  output logic [ADDR_W-1:0] dec_wr_addr,
  output logic [63:0]       dec_wr_data,
  output logic              tb_start,
  output logic [ADDR_W-1:0] tb_len,
  input  logic              tb_busy,
  output logic              frame_err
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    STEP,
    TB,
    TBWAIT,
    DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_SYMS - 1);

  state_t            state;
  logic [ADDR_W-1:0] sym_cnt;
  logic              last_r;
  logic [7:0]        met_next;
  logic              hs;

  assign hs          = in_valid & in_ready;
  assign dec_wr_addr = sym_cnt;
  assign dec_wr_data = dec_in;

  // Hamming distance of the received pair to each hypothesis h: {both differ, one differs}
  always_comb begin
    met_next = '0;
    for (int unsigned h = 0; h < 4; h++) begin
      logic [1:0] x;
      x = in_bits ^ 2'(h);
      met_next[2*h +: 2] = {x[1] & x[0], x[1] ^ x[0]};
    end
  end

  // Strobes are registered on the transition into the state that owns them,
  // so each is high exactly for the cycle spent in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sym_cnt   <= '0;
      last_r    <= 1'b0;
      metrics   <= '0;
      tb_len    <= '0;
      in_ready  <= 1'b0;
      acs_clear <= 1'b0;
      acs_step  <= 1'b0;
      dec_wr_en <= 1'b0;
      tb_start  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      acs_clear <= 1'b0;
      acs_step  <= 1'b0;
      dec_wr_en <= 1'b0;
      tb_start  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= CLEAR;
            acs_clear <= 1'b1;
          end
        end
        CLEAR: begin
          sym_cnt  <= '0;
          state    <= RUN;
          in_ready <= 1'b1;
        end
        RUN: begin
          if (hs) begin
            metrics   <= met_next;
            last_r    <= in_last;
            in_ready  <= 1'b0;
            acs_step  <= 1'b1;
            dec_wr_en <= 1'b1;
            frame_err <= !in_last && (sym_cnt == LAST_IDX);
            state     <= STEP;
          end
        end
        STEP: begin
          sym_cnt <= sym_cnt + ADDR_W'(1);
          if (last_r) begin
            state    <= TB;
            tb_start <= 1'b1;
            tb_len   <= sym_cnt + ADDR_W'(1);
          end else if (sym_cnt == LAST_IDX) begin
            state    <= DRAIN;
            in_ready <= 1'b1;
          end else begin
            state    <= RUN;
            in_ready <= 1'b1;
          end
        end
        TB: begin
          state <= TBWAIT;
        end
        TBWAIT: begin
          if (!tb_busy) state <= IDLE;
        end
        DRAIN: begin
          if (hs && in_last) begin
            state    <= IDLE;
            in_ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_acs_sequencer.sv
// Scoreboard bench for viterbi_acs_sequencer: driver queues expected writes,
// traceback launches and frame errors; a negedge monitor pops and compares.
module tb_viterbi_acs_sequencer;

  localparam int MAX = 48;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_bits = '0;
  logic        in_last = 1'b0;
  logic [7:0]  metrics;
  logic        acs_clear;
  logic        acs_step;
  logic [63:0] dec_in = '0;
  logic        dec_wr_en;
  logic [5:0]  dec_wr_addr;
  logic [63:0] dec_wr_data;
  logic        tb_start;
  logic [5:0]  tb_len;
  logic        tb_busy = 1'b0;
  logic        frame_err;

  viterbi_acs_sequencer #(.MAX_SYMS(MAX), .ADDR_W(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits), .in_last(in_last),
    .metrics(metrics), .acs_clear(acs_clear), .acs_step(acs_step),
    .dec_in(dec_in), .dec_wr_en(dec_wr_en), .dec_wr_addr(dec_wr_addr),
    .dec_wr_data(dec_wr_data), .tb_start(tb_start), .tb_len(tb_len),
    .tb_busy(tb_busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; logic [63:0] data; logic [7:0] met; int cyc; } wr_t;
  typedef struct { int len; int cyc; } tbx_t;

  wr_t  wq[$];
  tbx_t tq[$];
  int   eq[$];

  int compared = 0;
  int mismatched = 0;
  int clears = 0;
  int first_hs, last_hs;
  logic [7:0] last_met = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    mismatched++;
    $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Hand-computed metric bytes {h3,h2,h1,h0} for each received pair
  function automatic logic [7:0] exp_met(input logic [1:0] b);
    case (b)
      2'b00:   return 8'h94;
      2'b01:   return 8'h61;
      2'b10:   return 8'h49;
      default: return 8'h16;
    endcase
  endfunction

  function automatic logic [63:0] pat(input int fid, input int idx);
    return {16'hDEC0, 16'(fid), 16'(~idx), 16'(idx)};
  endfunction

  wr_t  mw;
  tbx_t mt;
  int   me;

  always @(negedge clk) begin
    if (!reset) begin
      if (acs_clear) clears++;
      if (acs_step || dec_wr_en) chk("acs_step_vs_wr_en", acs_step, dec_wr_en);
      if (dec_wr_en) begin
        if (wq.size() == 0) flag("unexpected_write", dec_wr_addr, 0);
        else begin
          mw = wq.pop_front();
          chk("wr_addr", dec_wr_addr, mw.addr);
          chk("wr_data", dec_wr_data, mw.data);
          chk("metrics", metrics, mw.met);
          chk("wr_cycle", cyc, mw.cyc);
        end
      end
      if (tb_start) begin
        if (tq.size() == 0) flag("unexpected_tb_start", tb_len, 0);
        else begin
          mt = tq.pop_front();
          chk("tb_len", tb_len, mt.len);
          chk("tb_start_cycle", cyc, mt.cyc);
        end
      end
      if (frame_err) begin
        if (eq.size() == 0) flag("unexpected_frame_err", cyc, 0);
        else begin
          me = eq.pop_front();
          chk("frame_err_cycle", cyc, me);
        end
      end
    end
  end

  // Presents pair idx of an n-pair frame; returns at the negedge after the handshake.
  task automatic send(input int idx, input int n, input int fid);
    logic [1:0] b;
    int t;
    int hs;
    b = 2'((idx * 3 + fid) % 4);
    in_valid = 1'b1;
    in_bits  = b;
    in_last  = (idx == n - 1);
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      flag("handshake_timeout", t, 300);
      in_valid = 1'b0;
      return;
    end
    hs = cyc;
    if (idx == 0) first_hs = hs;
    last_hs = hs;
    if (idx < MAX) begin
      wq.push_back('{addr: idx, data: pat(fid, idx), met: exp_met(b), cyc: hs + 1});
      last_met = exp_met(b);
    end
    if (idx == MAX - 1 && n > MAX) eq.push_back(hs + 1);
    if (idx == n - 1 && n <= MAX) tq.push_back('{len: n, cyc: hs + 2});
    @(posedge clk);
    #1 dec_in = pat(fid, idx);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((wq.size() != 0 || tq.size() != 0 || eq.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("pending_writes", wq.size(), 0);
    chk("pending_tb_start", tq.size(), 0);
    chk("pending_frame_err", eq.size(), 0);
    chk("idle_in_ready", in_ready, 0);
    chk("metrics_hold", metrics, last_met);
  endtask

  task automatic frame(input int n, input int fid);
    int c0;
    c0 = clears;
    for (int i = 0; i < n; i++) send(i, n, fid);
    wait_done();
    chk("acs_clear_count", clears - c0, 1);
  endtask

  initial begin
    int t;
    int c0;
    repeat (3) @(negedge clk);
    chk("rst_metrics", metrics, 0);
    chk("rst_tb_len", tb_len, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_strobes", {acs_clear, acs_step, dec_wr_en, tb_start, frame_err}, 0);
    reset = 1'b0;
    @(negedge clk);

    // single pair 2'b10 with in_last: tb_len=1, metrics 8'h49
    frame(1, 2);
    chk("single_tb_len_held", tb_len, 1);

    // 10 continuous pairs: one handshake every 2 cycles
    frame(10, 1);
    chk("ten_hs_spacing", last_hs - first_hs, 18);
    chk("ten_tb_len_held", tb_len, 10);

    // overlong frame: 48 writes, frame_err, drain, no traceback
    frame(50, 3);
    chk("err_tb_len_unchanged", tb_len, 10);

    // exactly MAX_SYMS symbols
    frame(48, 0);
    chk("max_tb_len_held", tb_len, 48);

    // traceback busy backpressure
    for (int i = 0; i < 3; i++) send(i, 3, 4);
    t = 0;
    while (!tb_start && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!tb_start) flag("tb_start_timeout", t, 50);
    tb_busy  = 1'b1;
    in_valid = 1'b1;
    in_bits  = 2'b00;
    c0 = clears;
    repeat (20) begin
      @(negedge clk);
      chk("busy_in_ready", in_ready, 0);
      chk("busy_acs_clear", acs_clear, 0);
    end
    chk("busy_tb_len", tb_len, 3);
    chk("busy_no_clear", clears - c0, 0);
    tb_busy = 1'b0;
    frame(2, 5);

    // reset during STEP of symbol 5
    for (int i = 0; i < 6; i++) send(i, 10, 6);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_strobes", {acs_clear, acs_step, dec_wr_en, tb_start, frame_err}, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_tb_len", tb_len, 0);
    chk("midrst_metrics", metrics, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_idle_no_clear", acs_clear, 0);
    frame(4, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", compared);
    $fatal(1);
  end

endmodule
